// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer.
// master = fetch + decode side driving the buffer, slave = the buffer itself.
interface if_id_buffer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_inst;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_pc4;
    logic [XLEN-1:0]  out_inst;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_pc4, out_inst, occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_pc4, out_inst, occupancy, stall_cnt
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry in-order IF/ID decoupling buffer with flush and saturating stall counter.
// Latency: an entry pushed at edge N is presented to decode after edge N.
// Backpressure: in_ready drops when both slots are held; it never looks at out_ready.
module if_id_buffer #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  NOP_INST = '0,
    parameter int               CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    if_id_buffer_if.slave  bus
);
    logic [XLEN-1:0]  slot_pc   [2];
    logic [XLEN-1:0]  slot_inst [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [CNT_W-1:0] stall_q;
    logic             push;
    logic             pop;
    logic             stall;

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);

    assign push  = bus.in_valid  & bus.in_ready  & ~bus.flush;
    assign pop   = bus.out_valid & bus.out_ready & ~bus.flush;
    assign stall = bus.out_valid & ~bus.out_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (bus.flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Slot contents need no reset: the empty case is masked on the outputs.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            slot_pc[wr_ptr]   <= bus.in_pc;
            slot_inst[wr_ptr] <= bus.in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (stall && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end

    assign bus.out_pc    = bus.out_valid ? slot_pc[rd_ptr]   : '0;
    assign bus.out_inst  = bus.out_valid ? slot_inst[rd_ptr] : NOP_INST;
    assign bus.out_pc4   = bus.out_pc + XLEN'(4);
    assign bus.occupancy = count;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_if_id_buffer.sv
// Randomised + directed bench for if_id_buffer, checked against a queue-based reference model.
module tb_if_id_buffer;
    localparam int          XLEN      = 32;
    localparam int          CNT_W     = 4;
    localparam int          STALL_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    entry_t model_q[$];
    int     m_stall = 0;

    if_id_buffer_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    if_id_buffer #(.XLEN(XLEN), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a bounded queue of at most two entries, updated from the inputs at each edge.
    always @(posedge clk) begin
        entry_t e;
        bit     acc;
        bit     deq;
        started <= 1'b1;
        if (rst) begin
            model_q.delete();
            m_stall = 0;
        end else if (bus.flush) begin
            model_q.delete();
        end else begin
            acc = bus.in_valid && (model_q.size() < 2);
            deq = (model_q.size() > 0) && bus.out_ready;
            if ((model_q.size() > 0) && !bus.out_ready && m_stall < STALL_MAX)
                m_stall++;
            if (deq) void'(model_q.pop_front());
            if (acc) begin
                e.pc   = bus.in_pc;
                e.inst = bus.in_inst;
                model_q.push_back(e);
            end
        end
    end

    // Monitor: compare every output mid-cycle against the model.
    always @(negedge clk) begin
        logic [31:0] exp_pc4;
        if (started) begin
            chk("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
            chk("occupancy", 32'(bus.occupancy), 32'(model_q.size()));
            chk("in_ready",  32'(bus.in_ready),  32'(model_q.size() != 2));
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
            if (model_q.size() != 0) begin
                exp_pc4 = model_q[0].pc + 32'd4;
                chk("out_pc",   bus.out_pc,   model_q[0].pc);
                chk("out_pc4",  bus.out_pc4,  exp_pc4);
                chk("out_inst", bus.out_inst, model_q[0].inst);
            end else begin
                chk("empty_pc",   bus.out_pc,   32'h0);
                chk("empty_pc4",  bus.out_pc4,  32'h4);
                chk("empty_inst", bus.out_inst, NOP);
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic r);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = $urandom;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_pc4",   bus.out_pc4,        32'h4);

        // Streaming: occupancy 1 throughout, entries in order.
        for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(4 * i), 1, 0, 0);
        @(negedge clk);
        chk("stream_head", bus.out_pc, 32'h10C);
        cyc(0, 0, 1, 0, 0);

        // Fill to two, attempt a third push, stall, then drain.
        cyc(1, 32'h200, 0, 0, 0);
        cyc(1, 32'h204, 0, 0, 0);
        cyc(1, 32'h208, 0, 0, 0);
        @(negedge clk);
        chk("full_ready", 32'(bus.in_ready), 32'h0);
        chk("full_head",  bus.out_pc,        32'h200);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("drain_pc4", bus.out_pc4, 32'h208);
        cyc(0, 0, 1, 0, 0);

        // Reset mid-traffic while full and pushing.
        cyc(1, 32'h300, 0, 0, 0);
        cyc(1, 32'h304, 0, 0, 0);
        cyc(1, 32'h308, 1, 0, 1);
        cyc(1, 32'h30C, 1, 0, 1);
        @(negedge clk);
        chk("rst_occ",   32'(bus.occupancy), 32'h0);
        chk("rst_inst",  bus.out_inst,       NOP);
        chk("rst_stall", 32'(bus.stall_cnt), 32'h0);

        // Flush while full with a simultaneous push and pop.
        cyc(1, 32'h400, 0, 0, 0);
        cyc(1, 32'h404, 0, 0, 0);
        cyc(1, 32'h408, 1, 1, 0);
        @(negedge clk);
        chk("flush_occ", 32'(bus.occupancy), 32'h0);

        // Simultaneous push/pop at count 1 across pointer wrap, ending at the PC wrap point.
        cyc(1, 32'h500, 0, 0, 0);
        for (int i = 1; i < 5; i++) cyc(1, 32'h500 + 32'(4 * i), 1, 0, 0);
        cyc(1, 32'hFFFF_FFFC, 1, 0, 0);
        @(negedge clk);
        chk("wrap_pc",  bus.out_pc,  32'hFFFF_FFFC);
        chk("wrap_pc4", bus.out_pc4, 32'h0);

        // Saturation of the stall counter.
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("stall_sat", 32'(bus.stall_cnt), 32'(STALL_MAX));

        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 63) == 0));
        cyc(0, 0, 1, 0, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
